// File: rtl/conv_result_fifo.sv
// Result buffer answering the fifo_command interface: WRITE captures one datapath result, READ drains to a MEM_READ-paced reader.
// Optional CONV_FIFO_SAT_EN: signed saturation of wr_data to DATA_W instead of truncation.
module conv_result_fifo #(
    parameter int unsigned ACC_W  = 20,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        fifo_command,
    input  logic [ACC_W-1:0]  wr_data,
    input  logic              MEM_READ,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              busy,
    output logic              drain_done,
    output logic              overflow
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [1:0] CMD_NOP   = 2'b00;
    localparam logic [1:0] CMD_WRITE = 2'b10;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        DRAIN  = 2'b01,
        FINISH = 2'b10
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [1:0]          cmd_q;
    logic                cmd_new;
    logic                wr_accept;
    logic                wr_drop;
    logic                handshake;
    logic                fetch;
    logic [CNT_W-1:0]    ram_cnt;
    logic [CNT_W-1:0]    count_nxt;
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W-1:0]   rd_ptr;
    logic [DATA_W-1:0]   wr_conv;
    logic [DATA_W-1:0]   mem [DEPTH];

`ifdef CONV_FIFO_SAT_EN
    // Bits at and above the result sign must all agree, otherwise clamp.
    logic [ACC_W-DATA_W:0] sat_top;

    always_comb begin
        sat_top = wr_data[ACC_W-1:DATA_W-1];
        wr_conv = wr_data[DATA_W-1:0];
        if ((sat_top != '0) && (sat_top != '1)) begin
            wr_conv = wr_data[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                       : {1'b0, {(DATA_W-1){1'b1}}};
        end
    end
`else
    logic unused_wr_hi;

    assign wr_conv      = wr_data[DATA_W-1:0];
    assign unused_wr_hi = ^wr_data[ACC_W-1:DATA_W];
`endif

    // Command edge detect, write acceptance and drain fetch decisions.
    always_comb begin
        cmd_new   = (fifo_command != cmd_q) && (fifo_command != CMD_NOP);
        wr_accept = cmd_new && (fifo_command == CMD_WRITE) && (state == IDLE) && !full;
        wr_drop   = cmd_new && (fifo_command == CMD_WRITE) && !wr_accept;
        handshake = rd_valid && MEM_READ;
        ram_cnt   = count - CNT_W'(rd_valid);
        fetch     = (state == DRAIN) && (!rd_valid || MEM_READ) && (ram_cnt != '0);
        count_nxt = count;
        if (wr_accept) begin
            count_nxt = count + CNT_W'(1);
        end else if (handshake) begin
            count_nxt = count - CNT_W'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_new && (fifo_command == CMD_READ)) state_nxt = DRAIN;
            DRAIN:   if (count == '0) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Pointers, presented word, occupancy and status flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cmd_q      <= CMD_NOP;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            count      <= '0;
            full       <= 1'b0;
            empty      <= 1'b1;
            busy       <= 1'b0;
            drain_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            cmd_q <= fifo_command;
            if (wr_accept) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (fetch) begin
                rd_data  <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + ADDR_W'(1);
                rd_valid <= 1'b1;
            end else if (handshake) begin
                rd_valid <= 1'b0;
            end
            count      <= count_nxt;
            full       <= (count_nxt == CNT_FULL);
            empty      <= (count_nxt == '0);
            busy       <= (state_nxt != IDLE);
            drain_done <= (state_nxt == FINISH);
            if (wr_drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= wr_conv;
        end
    end

endmodule

// File: tb/tb_conv_result_fifo.sv
// Randomized scoreboard bench for conv_result_fifo; expected words come from a queue model of the buffer.
module tb_conv_result_fifo;

    localparam int DEPTH = 256;

`ifdef CONV_FIFO_SAT_EN
    localparam logic [15:0] EXP_POS = 16'h7FFF;
    localparam logic [15:0] EXP_NEG = 16'h8000;
`else
    localparam logic [15:0] EXP_POS = 16'h2345;
    localparam logic [15:0] EXP_NEG = 16'h0000;
`endif

    logic        clk;
    logic        reset;
    logic [1:0]  fifo_command;
    logic [19:0] wr_data;
    logic        MEM_READ;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic [8:0]  count;
    logic        full;
    logic        empty;
    logic        busy;
    logic        drain_done;
    logic        overflow;

    int          tests = 0;
    int          fails = 0;
    logic [15:0] exp_q[$];
    bit          m_busy = 0;
    bit          exp_ovf = 0;
    bit          have_prev = 0;
    logic [15:0] prev_data;

    conv_result_fifo dut (
        .clk          (clk),
        .reset        (reset),
        .fifo_command (fifo_command),
        .wr_data      (wr_data),
        .MEM_READ     (MEM_READ),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .busy         (busy),
        .drain_done   (drain_done),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] conv_ref(input logic [19:0] d);
`ifdef CONV_FIFO_SAT_EN
        int v;
        v = int'($signed(d));
        if (v > 32767) return 16'h7FFF;
        if (v < -32768) return 16'h8000;
`endif
        return d[15:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Every transfer is checked against the model; a held word must not change.
    always @(negedge clk) begin
        if (!reset) begin
            have_prev = 0;
        end else begin
            if (have_prev) begin
                check("stable_valid", rd_valid, 1);
                check("stable_data", rd_data, prev_data);
            end
            if (rd_valid && MEM_READ) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_word: got 0x%0h expected no word", rd_data);
                end else begin
                    check("rd_data", rd_data, exp_q.pop_front());
                end
            end
            have_prev = rd_valid && !MEM_READ;
            prev_data = rd_data;
        end
    end

    task automatic do_write(input logic [19:0] d);
        wr_data      = d;
        fifo_command = 2'b10;
        if (m_busy || exp_q.size() >= DEPTH) exp_ovf = 1;
        else exp_q.push_back(conv_ref(d));
        cyc();
        fifo_command = 2'b00;
        cyc();
    endtask

    task automatic start_drain();
        fifo_command = 2'b01;
        m_busy       = 1;
        cyc();
        fifo_command = 2'b00;
    endtask

    // mode 0: MEM_READ high, 1: pattern 1,0,0,1, else random.
    task automatic wait_drain(input int mode, input int budget);
        logic [3:0] pat;
        bit         done;
        pat  = 4'b1001;
        done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            case (mode)
                0:       MEM_READ = 1'b1;
                1:       MEM_READ = pat[i % 4];
                default: MEM_READ = 1'($urandom_range(0, 1));
            endcase
            cyc();
            if (drain_done) done = 1;
        end
        MEM_READ = 1'b0;
        check("drain_done_seen", done, 1);
        cyc();
        check("drain_done_width", drain_done, 0);
        check("busy_after_drain", busy, 0);
        check("sb_drained", exp_q.size(), 0);
        check("count_after_drain", count, exp_q.size());
        check("empty_after_drain", empty, 1);
        m_busy = 0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_rd_valid"}, rd_valid, 0);
        check({tag, "_rd_data"}, rd_data, 0);
        check({tag, "_count"}, count, 0);
        check({tag, "_empty"}, empty, 1);
        check({tag, "_full"}, full, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_drain_done"}, drain_done, 0);
        check({tag, "_overflow"}, overflow, 0);
    endtask

    initial begin
        reset        = 1'b0;
        fifo_command = 2'b00;
        wr_data      = '0;
        MEM_READ     = 1'b0;
        repeat (3) cyc();
        check_reset_state("reset");
        reset = 1'b1;
        cyc();

        // Three single writes drained back to back.
        do_write(20'h00011);
        do_write(20'h00022);
        do_write(20'h00033);
        check("t1_count", count, exp_q.size());
        start_drain();
        MEM_READ = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            check("t1_consecutive_valid", rd_valid, 1);
        end
        wait_drain(0, 20);

        // A held WRITE stores once; READ following a held WRITE still starts a drain.
        wr_data      = 20'($urandom);
        fifo_command = 2'b10;
        exp_q.push_back(conv_ref(wr_data));
        repeat (5) cyc();
        check("t2_count", count, exp_q.size());
        fifo_command = 2'b01;
        m_busy       = 1;
        cyc();
        fifo_command = 2'b00;
        wait_drain(0, 20);

        // Reader toggling 1,0,0,1.
        for (int k = 0; k < 6; k++) do_write(20'($urandom));
        check("t4_count", count, exp_q.size());
        start_drain();
        wait_drain(1, 100);

        // Drain on an empty buffer.
        start_drain();
        check("t5_busy", busy, 1);
        check("t5_done_early", drain_done, 0);
        cyc();
        check("t5_done_pulse", drain_done, 1);
        check("t5_rd_valid", rd_valid, 0);
        cyc();
        check("t5_done_end", drain_done, 0);
        check("t5_busy_end", busy, 0);
        m_busy = 0;

        // Conversion boundaries.
        do_write(20'h12345);
        do_write(20'hF0000);
        start_drain();
        MEM_READ = 1'b0;
        cyc();
        check("t6_valid", rd_valid, 1);
        check("t6_pos", rd_data, EXP_POS);
        MEM_READ = 1'b1;
        cyc();
        check("t6_neg", rd_data, EXP_NEG);
        wait_drain(0, 20);

        // Random bursts with random reader pacing.
        for (int r = 0; r < 4; r++) begin
            int n;
            n = $urandom_range(1, 20);
            for (int k = 0; k < n; k++) do_write(20'($urandom));
            check("rand_count", count, exp_q.size());
            start_drain();
            wait_drain(2, 400);
        end

        // Fill, overflow, drain with pointer wrap.
        check("overflow_clear", overflow, exp_ovf);
        for (int k = 0; k < DEPTH; k++) do_write(20'($urandom));
        check("t3_full", full, 1);
        check("t3_count", count, exp_q.size());
        do_write(20'($urandom));
        check("t3_overflow", overflow, exp_ovf);
        check("t3_count_after_drop", count, exp_q.size());
        start_drain();
        wait_drain(2, 3000);
        check("t3_full_after", full, 0);
        do_write(20'($urandom));
        start_drain();
        wait_drain(0, 20);

        // Reset during a drain aborts it silently.
        for (int k = 0; k < 4; k++) do_write(20'($urandom));
        start_drain();
        MEM_READ = 1'b1;
        cyc();
        cyc();
        reset    = 1'b0;
        MEM_READ = 1'b0;
        cyc();
        check_reset_state("midreset");
        reset   = 1'b1;
        exp_q.delete();
        exp_ovf = 0;
        m_busy  = 0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            check("midreset_no_done", drain_done, 0);
        end

        // WRITE during a drain is dropped and flags overflow.
        do_write(20'($urandom));
        do_write(20'($urandom));
        start_drain();
        MEM_READ = 1'b0;
        do_write(20'($urandom));
        check("drain_write_overflow", overflow, exp_ovf);
        wait_drain(0, 20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
